rob_commit: RTL and testbench

- Writer-side counterpart of the issue-stage operand read path.
- Tracks in-flight results per ROB entry, accepts execution writebacks, and retires them in order.
- Drives the GPR/FPR write ports, plus the commit bypass triple (commit_e_, commit_rob_id, commit_data) that the issue-stage operand selection consumes.
- Sits between the execution-unit writeback bus and the architectural register files.

---
 rtl/rob_commit_pkg.sv | 36 +++
 rtl/rob_ring_ptr.sv | 22 ++
 rtl/rob_commit.sv | 161 ++++++++++++++++
 tb/tb_rob_commit.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared types and sizes for the ROB commit block: register-file destination,
// ROB entry payload and the active-low enable encoding.
package rob_commit_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROB_DEPTH  = 8;
  localparam int unsigned ROB_W      = $clog2(ROB_DEPTH);
  localparam int unsigned CNT_W      = ROB_W + 1;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned FPR_ADDR_W = 5;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    TYPE_NONE = 2'd0,
    TYPE_GPR  = 2'd1,
    TYPE_FPR  = 2'd2,
    TYPE_CSR  = 2'd3
  } regtype_e;

  typedef struct packed {
    regtype_e                regtype;
    logic [REG_ADDR_W-1:0]   addr;
  } regfile_t;

  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic                    exp;
    regfile_t                rd;
    logic [DATA_WIDTH-1:0]   data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ring_ptr.sv
// Wrapping ROB pointer: increments modulo 2**W, synchronous clear has priority.
module rob_ring_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_commit.sv
// In-order ROB commit stage: tracks results per entry and retires the head.
// ROB_SAME_CYCLE_COMMIT_EN lets a writeback to the head retire in the same cycle.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   alloc_e_,
  input  regfile_t               alloc_rd,
  output logic [ROB_W-1:0]       alloc_rob_id,
  output logic                   rob_full,
  output logic                   rob_empty,
  input  logic                   wb_e_,
  input  logic [ROB_W-1:0]       wb_rob_id,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic                   wb_exp_,
  output logic                   commit_e_,
  output logic [ROB_W-1:0]       commit_rob_id,
  output logic [DATA_WIDTH-1:0]  commit_data,
  output logic                   gpr_we_,
  output logic [GPR_ADDR_W-1:0]  gpr_waddr,
  output logic [DATA_WIDTH-1:0]  gpr_wdata,
  output logic                   fpr_we_,
  output logic [FPR_ADDR_W-1:0]  fpr_waddr,
  output logic [DATA_WIDTH-1:0]  fpr_wdata,
  output logic                   flush_
);

  rob_entry_t             rob_q [ROB_DEPTH];
  rob_entry_t             head_ent;
  logic [ROB_W-1:0]       head;
  logic [ROB_W-1:0]       tail;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic                   full_q;
  logic                   empty_q;

  logic                   wb_ok_c;
  logic                   wb_store_c;
  logic                   bypass_c;
  logic                   commit_c;
  logic                   cexp_c;
  logic [DATA_WIDTH-1:0]  cdata_c;
  logic                   flush_c;
  logic                   alloc_ok_c;
  logic                   gpr_wr_c;
  logic                   fpr_wr_c;

  rob_ring_ptr #(.W(ROB_W)) u_head (
    .clk   (clk),
    .rst_n (reset_),
    .inc   (commit_c),
    .clr   (flush_c),
    .ptr   (head)
  );

  rob_ring_ptr #(.W(ROB_W)) u_tail (
    .clk   (clk),
    .rst_n (reset_),
    .inc   (alloc_ok_c),
    .clr   (flush_c),
    .ptr   (tail)
  );

  // Commit decision and the accept conditions it gates
  always_comb begin
    head_ent = rob_q[head];
    wb_ok_c  = !wb_e_ && rob_q[wb_rob_id].valid && !rob_q[wb_rob_id].done;
`ifdef ROB_SAME_CYCLE_COMMIT_EN
    bypass_c = wb_ok_c && (wb_rob_id == head);
    cdata_c  = bypass_c ? wb_data : head_ent.data;
    cexp_c   = bypass_c ? !wb_exp_ : head_ent.exp;
`else
    bypass_c = 1'b0;
    cdata_c  = head_ent.data;
    cexp_c   = head_ent.exp;
`endif
    commit_c   = (head_ent.valid && head_ent.done) || bypass_c;
    flush_c    = commit_c && cexp_c;
    alloc_ok_c = !alloc_e_ && !full_q && !flush_c;
    wb_store_c = wb_ok_c && !flush_c && !bypass_c;
    gpr_wr_c   = commit_c && !cexp_c && (head_ent.rd.regtype == TYPE_GPR) &&
                 (head_ent.rd.addr != '0);
    fpr_wr_c   = commit_c && !cexp_c && (head_ent.rd.regtype == TYPE_FPR);
  end

  always_comb begin
    count_d = count_q;
    if (flush_c) begin
      count_d = '0;
    end else if (alloc_ok_c && !commit_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (commit_c && !alloc_ok_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        rob_q[ROB_W'(i)] <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(ROB_DEPTH));
      empty_q <= (count_d == '0);
      if (flush_c) begin
        for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
          rob_q[ROB_W'(i)].valid <= 1'b0;
          rob_q[ROB_W'(i)].done  <= 1'b0;
          rob_q[ROB_W'(i)].exp   <= 1'b0;
        end
      end else begin
        if (alloc_ok_c) begin
          rob_q[tail].valid <= 1'b1;
          rob_q[tail].done  <= 1'b0;
          rob_q[tail].exp   <= 1'b0;
          rob_q[tail].rd    <= alloc_rd;
        end
        if (wb_store_c) begin
          rob_q[wb_rob_id].done <= 1'b1;
          rob_q[wb_rob_id].exp  <= !wb_exp_;
          rob_q[wb_rob_id].data <= wb_data;
        end
        // Retire last so it wins over a same-edge update of the head entry
        if (commit_c) begin
          rob_q[head].valid <= 1'b0;
          rob_q[head].done  <= 1'b0;
        end
      end
    end
  end

  assign alloc_rob_id  = tail;
  assign rob_full      = full_q;
  assign rob_empty     = empty_q;
  assign commit_e_     = commit_c ? ENABLE_ : DISABLE_;
  assign commit_rob_id = commit_c ? head : '0;
  assign commit_data   = commit_c ? cdata_c : '0;
  assign flush_        = flush_c ? ENABLE_ : DISABLE_;
  assign gpr_we_       = gpr_wr_c ? ENABLE_ : DISABLE_;
  assign gpr_waddr     = gpr_wr_c ? GPR_ADDR_W'(head_ent.rd.addr) : '0;
  assign gpr_wdata     = gpr_wr_c ? cdata_c : '0;
  assign fpr_we_       = fpr_wr_c ? ENABLE_ : DISABLE_;
  assign fpr_waddr     = fpr_wr_c ? FPR_ADDR_W'(head_ent.rd.addr) : '0;
  assign fpr_wdata     = fpr_wr_c ? cdata_c : '0;

`ifndef SYNTHESIS
  // A writeback must target a live entry that has not produced its result yet
  always @(posedge clk) begin
    if (reset_ && !wb_e_) begin
      assert (rob_q[wb_rob_id].valid && !rob_q[wb_rob_id].done)
        else $error("rob_commit: writeback to invalid or completed entry %0d", wb_rob_id);
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: queue-based in-order retirement model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rob_commit;
  import rob_commit_pkg::*;

  localparam int DEPTH = int'(ROB_DEPTH);

  logic                  clk = 1'b0;
  logic                  reset_;
  logic                  alloc_e_;
  regfile_t              alloc_rd;
  logic [ROB_W-1:0]      alloc_rob_id;
  logic                  rob_full;
  logic                  rob_empty;
  logic                  wb_e_;
  logic [ROB_W-1:0]      wb_rob_id;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_exp_;
  logic                  commit_e_;
  logic [ROB_W-1:0]      commit_rob_id;
  logic [DATA_WIDTH-1:0] commit_data;
  logic                  gpr_we_;
  logic [GPR_ADDR_W-1:0] gpr_waddr;
  logic [DATA_WIDTH-1:0] gpr_wdata;
  logic                  fpr_we_;
  logic [FPR_ADDR_W-1:0] fpr_waddr;
  logic [DATA_WIDTH-1:0] fpr_wdata;
  logic                  flush_;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk           (clk),
    .reset_        (reset_),
    .alloc_e_      (alloc_e_),
    .alloc_rd      (alloc_rd),
    .alloc_rob_id  (alloc_rob_id),
    .rob_full      (rob_full),
    .rob_empty     (rob_empty),
    .wb_e_         (wb_e_),
    .wb_rob_id     (wb_rob_id),
    .wb_data       (wb_data),
    .wb_exp_       (wb_exp_),
    .commit_e_     (commit_e_),
    .commit_rob_id (commit_rob_id),
    .commit_data   (commit_data),
    .gpr_we_       (gpr_we_),
    .gpr_waddr     (gpr_waddr),
    .gpr_wdata     (gpr_wdata),
    .fpr_we_       (fpr_we_),
    .fpr_waddr     (fpr_waddr),
    .fpr_wdata     (fpr_wdata),
    .flush_        (flush_)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the in-flight instructions in program order
  typedef struct {
    int                    id;
    regfile_t              rd;
    bit                    done;
    bit                    exp;
    logic [DATA_WIDTH-1:0] data;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_tail = 0;

  always @(negedge clk) begin
    bit                    c;
    bit                    bypass;
    bit                    cx;
    bit                    fl;
    bit                    g;
    bit                    f;
    bit                    a_ok;
    int                    cid;
    regfile_t              crd;
    logic [DATA_WIDTH-1:0] cd;
    c = 0; bypass = 0; cx = 0; cid = 0; crd = '0; cd = '0;
    if (!reset_) begin
      check("rst_commit_e_", 64'(commit_e_), 64'd1);
      check("rst_flush_", 64'(flush_), 64'd1);
      check("rst_gpr_we_", 64'(gpr_we_), 64'd1);
      check("rst_fpr_we_", 64'(fpr_we_), 64'd1);
      check("rst_rob_empty", 64'(rob_empty), 64'd1);
      check("rst_rob_full", 64'(rob_full), 64'd0);
      check("rst_alloc_rob_id", 64'(alloc_rob_id), 64'd0);
      check("rst_commit_data", 64'(commit_data), 64'd0);
      check("rst_gpr_wdata", 64'(gpr_wdata), 64'd0);
      check("rst_fpr_waddr", 64'(fpr_waddr), 64'd0);
      mq.delete();
      m_tail = 0;
    end else begin
`ifdef ROB_SAME_CYCLE_COMMIT_EN
      bypass = !wb_e_ && mq.size() > 0 && mq[0].id == int'(wb_rob_id) && !mq[0].done;
`endif
      c = (mq.size() > 0 && mq[0].done) || bypass;
      if (c) begin
        cid = mq[0].id;
        crd = mq[0].rd;
        cd  = bypass ? wb_data : mq[0].data;
        cx  = bypass ? !wb_exp_ : mq[0].exp;
      end
      fl = c && cx;
      g  = c && !cx && crd.regtype == TYPE_GPR && crd.addr != '0;
      f  = c && !cx && crd.regtype == TYPE_FPR;

      check("rob_empty", 64'(rob_empty), 64'(mq.size() == 0));
      check("rob_full", 64'(rob_full), 64'(mq.size() == DEPTH));
      check("alloc_rob_id", 64'(alloc_rob_id), 64'(m_tail));
      check("commit_e_", 64'(commit_e_), 64'(!c));
      check("flush_", 64'(flush_), 64'(!fl));
      check("gpr_we_", 64'(gpr_we_), 64'(!g));
      check("fpr_we_", 64'(fpr_we_), 64'(!f));
      if (c) begin
        check("commit_rob_id", 64'(commit_rob_id), 64'(cid));
        check("commit_data", 64'(commit_data), 64'(cd));
      end
      if (g) begin
        check("gpr_waddr", 64'(gpr_waddr), 64'(crd.addr));
        check("gpr_wdata", 64'(gpr_wdata), 64'(cd));
      end
      if (f) begin
        check("fpr_waddr", 64'(fpr_waddr), 64'(crd.addr));
        check("fpr_wdata", 64'(fpr_wdata), 64'(cd));
      end

      a_ok = !alloc_e_ && mq.size() < DEPTH && !fl;
      if (fl) begin
        mq.delete();
        m_tail = 0;
      end else begin
        if (!wb_e_ && !bypass) begin
          foreach (mq[k]) begin
            if (mq[k].id == int'(wb_rob_id) && !mq[k].done) begin
              mq[k].done = 1;
              mq[k].exp  = !wb_exp_;
              mq[k].data = wb_data;
            end
          end
        end
        if (c) void'(mq.pop_front());
        if (a_ok) begin
          mq.push_back('{id: m_tail, rd: alloc_rd, done: 0, exp: 0, data: '0});
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  // Commits seen by the stimulus side, for the directed literal checks
  typedef struct {
    int                    id;
    logic [DATA_WIDTH-1:0] cd;
    logic                  gwe;
    logic [GPR_ADDR_W-1:0] ga;
    logic [DATA_WIDTH-1:0] gd;
    logic                  fwe;
    logic [FPR_ADDR_W-1:0] fa;
    logic                  fl;
  } obs_t;

  obs_t obs[$];

  function automatic regfile_t mkrd(input regtype_e t, input int a);
    regfile_t r;
    r.regtype = t;
    r.addr    = REG_ADDR_W'(a);
    return r;
  endfunction

  // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1
  task automatic step(input bit a, input regfile_t rd, input bit w, input int wid,
                      input logic [DATA_WIDTH-1:0] wd, input bit wx);
    alloc_e_  = !a;
    alloc_rd  = rd;
    wb_e_     = !w;
    wb_rob_id = ROB_W'(wid);
    wb_data   = wd;
    wb_exp_   = !wx;
    #2;
    if (commit_e_ === 1'b0)
      obs.push_back('{id: int'(commit_rob_id), cd: commit_data, gwe: gpr_we_, ga: gpr_waddr,
                      gd: gpr_wdata, fwe: fpr_we_, fa: fpr_waddr, fl: flush_});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, 0, '0, 0);
  endtask

  task automatic alloc(input regfile_t rd);
    step(1, rd, 0, 0, '0, 0);
  endtask

  task automatic wb(input int id, input logic [DATA_WIDTH-1:0] d, input bit x);
    step(0, '0, 1, id, d, x);
  endtask

  task automatic drain();
    int pick;
    for (int n = 0; n < 200 && mq.size() > 0; n++) begin
      pick = -1;
      foreach (mq[k]) if (pick < 0 && !mq[k].done) pick = mq[k].id;
      if (pick >= 0) wb(pick, DATA_WIDTH'($urandom), 0);
      else idle();
    end
    idle();
    check("drain_empty", 64'(rob_empty), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    int wraps;
    int nfl;
    int t;
    int cand[$];
    reset_ = 1'b0;
    alloc_e_ = 1'b1; alloc_rd = '0; wb_e_ = 1'b1; wb_rob_id = '0; wb_data = '0; wb_exp_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lit_reset_empty", 64'(rob_empty), 64'd1);
    check("lit_reset_commit_e_", 64'(commit_e_), 64'd1);
    reset_ = 1'b1;

    // In-order commit of out-of-order writebacks
    obs.delete();
    check("t1_alloc_id0", 64'(alloc_rob_id), 64'd0);
    alloc(mkrd(TYPE_GPR, 5));
    check("t1_alloc_id1", 64'(alloc_rob_id), 64'd1);
    alloc(mkrd(TYPE_GPR, 6));
    check("t1_alloc_id2", 64'(alloc_rob_id), 64'd2);
    alloc(mkrd(TYPE_GPR, 7));
    wb(2, 32'h30, 0);
    wb(0, 32'h10, 0);
    wb(1, 32'h20, 0);
    repeat (3) idle();
    check("t1_ncommits", 64'(obs.size()), 64'd3);
    for (int k = 0; k < obs.size() && k < 3; k++) begin
      check("t1_commit_id", 64'(obs[k].id), 64'(k));
      check("t1_gpr_we_", 64'(obs[k].gwe), 64'd0);
      check("t1_gpr_waddr", 64'(obs[k].ga), 64'(5 + k));
      check("t1_gpr_wdata", 64'(obs[k].gd), 64'(32'h10 * (k + 1)));
    end

    // Fill to full, overflow alloc, alloc+commit while full
    for (int k = 0; k < DEPTH; k++) alloc(mkrd(TYPE_GPR, k + 1));
    check("t2_full", 64'(rob_full), 64'd1);
    check("t2_tail_wrapped", 64'(alloc_rob_id), 64'd3);
    alloc(mkrd(TYPE_GPR, 9));
    check("t2_full_after_extra", 64'(rob_full), 64'd1);
    check("t2_tail_unchanged", 64'(alloc_rob_id), 64'd3);
`ifdef ROB_SAME_CYCLE_COMMIT_EN
    step(1, mkrd(TYPE_GPR, 9), 1, 3, 32'h33, 0);
`else
    wb(3, 32'h33, 0);
    alloc(mkrd(TYPE_GPR, 9));
`endif
    check("t2_not_full", 64'(rob_full), 64'd0);
    check("t2_alloc_ignored", 64'(alloc_rob_id), 64'd3);
    drain();

    // Wrap-around over two laps
    obs.delete();
    for (int k = 0; k < 2 * DEPTH; k++) begin
      t = m_tail;
      alloc(mkrd(TYPE_GPR, 1 + (k % 31)));
      wb(t, DATA_WIDTH'(k), 0);
      idle();
    end
    check("t3_ncommits", 64'(obs.size()), 64'(2 * DEPTH));
    bad = 0;
    wraps = 0;
    for (int k = 1; k < obs.size(); k++) begin
      if (obs[k].id != (obs[k-1].id + 1) % DEPTH) bad++;
      if (obs[k-1].id == DEPTH - 1 && obs[k].id == 0) wraps++;
    end
    check("t3_first_id", 64'(obs.size() > 0 ? obs[0].id : -1), 64'd3);
    check("t3_seq_gaps", 64'(bad), 64'd0);
    check("t3_wraps", 64'(wraps), 64'd2);

    // Exception on the second of four entries
    obs.delete();
    for (int k = 0; k < 4; k++) alloc(mkrd(TYPE_GPR, 10 + k));
    wb(3, 32'hA0, 0);
    wb(4, 32'hB0, 1);
    repeat (3) idle();
    check("t4_ncommits", 64'(obs.size()), 64'd2);
    nfl = 0;
    foreach (obs[k]) if (obs[k].fl == 1'b0) nfl++;
    check("t4_flush_pulses", 64'(nfl), 64'd1);
    if (obs.size() == 2) begin
      check("t4_c0_id", 64'(obs[0].id), 64'd3);
      check("t4_c0_gpr_we_", 64'(obs[0].gwe), 64'd0);
      check("t4_c1_id", 64'(obs[1].id), 64'd4);
      check("t4_c1_gpr_we_", 64'(obs[1].gwe), 64'd1);
      check("t4_c1_flush_", 64'(obs[1].fl), 64'd0);
    end
    check("t4_empty", 64'(rob_empty), 64'd1);
    check("t4_tail_zero", 64'(alloc_rob_id), 64'd0);

    // x0 is never written; FPR destination
    obs.delete();
    alloc(mkrd(TYPE_GPR, 0));
    alloc(mkrd(TYPE_FPR, 3));
    wb(0, 32'hFF, 0);
    wb(1, 32'hAB, 0);
    repeat (3) idle();
    check("t5_ncommits", 64'(obs.size()), 64'd2);
    if (obs.size() == 2) begin
      check("t5_x0_gpr_we_", 64'(obs[0].gwe), 64'd1);
      check("t5_x0_data", 64'(obs[0].cd), 64'hFF);
      check("t5_fpr_we_", 64'(obs[1].fwe), 64'd0);
      check("t5_fpr_waddr", 64'(obs[1].fa), 64'd3);
      check("t5_fpr_data", 64'(obs[1].cd), 64'hAB);
    end

    // Reset with five pending entries
    for (int k = 0; k < 5; k++) alloc(mkrd(TYPE_GPR, 20 + k));
    wb(2, 32'h55, 0);
    reset_ = 1'b0;
    alloc_e_ = 1'b1; wb_e_ = 1'b0; wb_rob_id = ROB_W'(2); wb_data = 32'h77; wb_exp_ = 1'b1;
    #2;
    check("t6_commit_e_", 64'(commit_e_), 64'd1);
    check("t6_gpr_we_", 64'(gpr_we_), 64'd1);
    check("t6_empty", 64'(rob_empty), 64'd1);
    check("t6_tail", 64'(alloc_rob_id), 64'd0);
    @(posedge clk);
    #1;
    wb_e_ = 1'b1;
    reset_ = 1'b1;
    obs.delete();
    repeat (3) idle();
    check("t6_no_commit", 64'(obs.size()), 64'd0);
    check("t6_empty_after", 64'(rob_empty), 64'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit a;
      bit w;
      int wid;
      cand.delete();
      foreach (mq[k]) if (!mq[k].done) cand.push_back(mq[k].id);
      a = ($urandom_range(0, 7) < 5);
      w = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
      wid = (cand.size() > 0) ? cand[$urandom_range(0, cand.size() - 1)] : 0;
      step(a, mkrd(regtype_e'(2'($urandom_range(0, 3))), int'($urandom_range(0, 31))),
           w, wid, DATA_WIDTH'($urandom), ($urandom_range(0, 19) == 0));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
